latch_write_ctrl: RTL
=====================

Name: latch_write_ctrl

Overview:
- Upstream feeder for the 8-bit D-latch memory.
- Collects a serial bit stream over a valid/ready handshake and assembles it MSB-first into a WIDTH-bit word.
- Presents the word on a registered data bus, then generates a clean, registered enable pulse with guaranteed setup and hold margins around it.
- Data bus stays frozen between writes, so the latch inputs are always stable while enable is high.

Parameters:
WIDTH, 8, word width; must equal the latch memory width; must be >= 2.
SETUP_CYCLES, 1, cycles data_out is stable before latch_en rises; must be >= 1.
EN_CYCLES, 2, cycles latch_en is held high; must be >= 1.
HOLD_CYCLES, 1, cycles data_out is stable after latch_en falls; must be >= 1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
bit_in  input  1  serial data bit, MSB of the word first.
bit_valid  input  1  bit_in is valid this cycle.
bit_ready  output  1  block accepts a bit this cycle (registered).
data_out  output  WIDTH  word driven to the latch D inputs (registered).
latch_en  output  1  latch enable, drives E (registered, glitch-free).
busy  output  1  high in SETUP, ENABLE and HOLD.
done  output  1  one-cycle pulse when a write sequence completes.
write_count  output  8  completed-write counter; wraps 255 -> 0.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; shift register and bit counter cleared; timer cleared.
  - data_out = 0, latch_en = 0, bit_ready = 0, busy = 0, done = 0, write_count = 0.
- States: IDLE, SHIFT, SETUP, ENABLE, HOLD.
- IDLE: first clock edge after reset release moves to SHIFT and sets bit_ready = 1.
- SHIFT:
  - bit_ready = 1.
  - A bit is accepted on an edge where bit_valid && bit_ready: shift_reg <= {shift_reg[WIDTH-2:0], bit_in}; bit_cnt increments.
  - bit_valid low means no shift and no count change; there is no timeout.
  - On the edge that accepts bit WIDTH (bit_cnt == WIDTH-1):
    - data_out <= completed word, i.e. the shifted value including this bit.
    - bit_cnt <= 0; bit_ready <= 0; timer <= 0; state -> SETUP.
- SETUP: latch_en = 0. After SETUP_CYCLES cycles: latch_en <= 1, timer <= 0, state -> ENABLE.
- ENABLE: latch_en = 1. After EN_CYCLES cycles: latch_en <= 0, timer <= 0, state -> HOLD.
- HOLD: latch_en = 0. After HOLD_CYCLES cycles, on the same edge:
  - state -> SHIFT; bit_ready <= 1; done <= 1 for exactly one cycle; write_count <= write_count + 1 (mod 256).
- data_out changes only on the final-bit accept edge; it holds the last written word at all other times, including in SHIFT.
- bit_valid outside SHIFT is ignored; no bit is consumed. The source must wait for bit_ready.
- Default-parameter latency, with edge N accepting the final bit:
  - data_out valid after N.
  - latch_en high after N+1 through N+3.
  - bit_ready and done high after N+4.
  - bit_ready is low for 4 cycles.
- Reset mid-sequence (any state) aborts immediately to the reset values. Partial words are discarded, and latch_en drops asynchronously.
- Timer width is clog2 of max(SETUP_CYCLES, EN_CYCLES, HOLD_CYCLES) + 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset release, bit_valid low -> bit_ready = 1 after first edge; data_out = 0x00; latch_en = 0; write_count = 0.
- Send 0xA5 MSB-first (1,0,1,0,0,1,0,1), bit_valid continuous:
  - data_out = 0xA5 after the 8th accept edge.
  - latch_en high exactly 2 cycles, starting 1 cycle later.
  - done pulses once 4 cycles after the accept.
  - write_count = 1.
- Send 0x3C with bit_valid deasserted for 3 random gaps -> data_out = 0x3C. data_out holds 0xA5 throughout shifting, and never changes while latch_en = 1.
- Assert bit_valid continuously through SETUP/ENABLE/HOLD -> no bits consumed while bit_ready = 0. The next word starts cleanly after done; send 0xFF -> data_out = 0xFF.
- Pull rst_n low during ENABLE -> latch_en = 0 immediately; data_out = 0x00. After release, 0x81 writes correctly.
- Perform 256 writes -> write_count wraps to 0 after the 256th. With SETUP/EN/HOLD = 2/3/2, measure latch_en width = 3 cycles and the setup/hold gaps = 2 cycles.

Source files
------------

// File: rtl/latch_write_ctrl.sv
// latch_write_ctrl: assembles a serial MSB-first bit stream into a word and writes it to a
// D-latch memory with a registered enable pulse framed by setup and hold intervals.
module latch_write_ctrl #(
  parameter int WIDTH        = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             latch_en,
  output logic             busy,
  output logic             done,
  output logic [7:0]       write_count
);
  localparam int MAXC = (SETUP_CYCLES > EN_CYCLES) ?
                        ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                        ((EN_CYCLES > HOLD_CYCLES) ? EN_CYCLES : HOLD_CYCLES);
  localparam int TW = $clog2(MAXC + 1);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, SHIFT, SETUP, ENABLE, HOLD} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d, word;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             ready_q, ready_d, en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             accept;
  assign word   = {shift_q[WIDTH-2:0], bit_in};
  assign accept = bit_valid && ready_q && (state_q == SHIFT);
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    ready_d = ready_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        state_d = SHIFT;
        ready_d = 1'b1;
      end
      SHIFT: if (accept) begin
        shift_d = word;
        if (cnt_q == CW'(WIDTH - 1)) begin
          data_d  = word;
          cnt_d   = '0;
          ready_d = 1'b0;
          timer_d = '0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SETUP: if (timer_q == TW'(SETUP_CYCLES - 1)) begin
        en_d    = 1'b1;
        timer_d = '0;
        state_d = ENABLE;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      ENABLE: if (timer_q == TW'(EN_CYCLES - 1)) begin
        en_d    = 1'b0;
        timer_d = '0;
        state_d = HOLD;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      HOLD: if (timer_q == TW'(HOLD_CYCLES - 1)) begin
        timer_d = '0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        wcnt_d  = wcnt_q + 8'd1;
        state_d = SHIFT;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // Async clear so latch_en drops the moment reset asserts, whatever the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wcnt_q  <= wcnt_d;
    end
  end
  assign bit_ready   = ready_q;
  assign data_out    = data_q;
  assign latch_en    = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign write_count = wcnt_q;
endmodule
